// File: rtl/odd_ticket_arbiter.sv
// odd_ticket_arbiter: round-robin arbiter that issues a one-cycle one-hot grant
// and tags each grant with an odd 8-bit ticket (1,3,...,255,1,...).
// An optional idle gap can follow each grant.
//
// Ports:
//   i_clk         - clock, rising edge
//   i_rst_n       - synchronous active-low reset
//   i_req         - level request per requester
//   i_clr         - synchronous clear of the ticket counter back to 1
//   o_gnt         - one-hot grant pulse (registered)
//   o_gnt_valid   - high exactly when o_gnt is nonzero
//   o_ticket      - ticket carried by the grant (0 when no grant)
//   o_wrap        - pulses with the grant carrying ticket 255
//   o_busy        - high while in GRANT or GAP
//   o_grant_total - saturating grant count (only with ODD_TICKET_ARBITER_STATS_EN)
//
// Build option: define ODD_TICKET_ARBITER_STATS_EN to add o_grant_total.
module odd_ticket_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_clr,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_gnt_valid,
    output logic [7:0]       o_ticket,
    output logic             o_wrap,
    output logic             o_busy
`ifdef ODD_TICKET_ARBITER_STATS_EN
    ,
    output logic [15:0]      o_grant_total
`endif
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned GAP_W = 4;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e             state_q,      state_d;
    logic [GAP_W-1:0]   gap_cnt_q,    gap_cnt_d;
    logic [PTR_W-1:0]   last_q,       last_d;
    logic [7:0]         ticket_q,     ticket_d;
    logic [N_REQ-1:0]   gnt_q,        gnt_d;
    logic               gnt_valid_q,  gnt_valid_d;
    logic [7:0]         out_tkt_q,    out_tkt_d;
    logic               wrap_q,       wrap_d;
    logic               busy_q,       busy_d;
`ifdef ODD_TICKET_ARBITER_STATS_EN
    logic [15:0]        total_q,      total_d;
`endif

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [N_REQ-1:0]   win_oh;
    logic               sample;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = last_q;
        win_oh    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(last_q) + k) % N_REQ;
            if (!win_found && i_req[PTR_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
        if (win_found) begin
            win_oh[win_idx] = 1'b1;
        end
    end

    // Next-state, ticket and output logic.
    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        last_d      = last_q;
        ticket_d    = ticket_q;
        gnt_d       = '0;
        out_tkt_d   = 8'd0;
        wrap_d      = 1'b0;
        sample      = 1'b0;

        case (state_q)
            ST_IDLE: sample = 1'b1;
            ST_GRANT: begin
                if (GAP_CYCLES > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end else begin
                    sample = 1'b1;
                end
            end
            ST_GAP: begin
                // The edge that ends the gap is also a sampling edge, so a
                // held request is granted without an extra idle cycle.
                if (gap_cnt_q == GAP_LAST) begin
                    sample = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (sample) begin
            gap_cnt_d = '0;
            if (win_found) begin
                state_d   = ST_GRANT;
                gnt_d     = win_oh;
                last_d    = win_idx;
                out_tkt_d = ticket_q;
                wrap_d    = (ticket_q == 8'd255);
                ticket_d  = ticket_q + 8'd2;
            end else begin
                state_d = ST_IDLE;
            end
        end

        // Clear wins over the post-grant increment.
        if (i_clr) begin
            ticket_d = 8'd1;
        end

        gnt_valid_d = |gnt_d;
        busy_d      = (state_d != ST_IDLE);
    end

`ifdef ODD_TICKET_ARBITER_STATS_EN
    always_comb begin
        total_d = total_q;
        if (|gnt_d && (total_q != 16'hFFFF)) begin
            total_d = total_q + 16'd1;
        end
    end
`endif

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= '0;
            last_q      <= PTR_W'(N_REQ - 1);
            ticket_q    <= 8'd1;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            out_tkt_q   <= 8'd0;
            wrap_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ODD_TICKET_ARBITER_STATS_EN
            total_q     <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            last_q      <= last_d;
            ticket_q    <= ticket_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            out_tkt_q   <= out_tkt_d;
            wrap_q      <= wrap_d;
            busy_q      <= busy_d;
`ifdef ODD_TICKET_ARBITER_STATS_EN
            total_q     <= total_d;
`endif
        end
    end

    assign o_gnt       = gnt_q;
    assign o_gnt_valid = gnt_valid_q;
    assign o_ticket    = out_tkt_q;
    assign o_wrap      = wrap_q;
    assign o_busy      = busy_q;
`ifdef ODD_TICKET_ARBITER_STATS_EN
    assign o_grant_total = total_q;
`endif

endmodule

// File: tb/tb_odd_ticket_arbiter.sv
// Bench for odd_ticket_arbiter: two instances (no gap, gap of 3) share the
// same stimulus and are compared every cycle against a cycle-level model.
module tb_odd_ticket_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       clr;

    logic [3:0] gnt_a, gnt_b;
    logic       gv_a, gv_b;
    logic [7:0] tkt_a, tkt_b;
    logic       wrap_a, wrap_b;
    logic       busy_a, busy_b;
`ifdef ODD_TICKET_ARBITER_STATS_EN
    logic [15:0] tot_a, tot_b;
`endif

    always #5 clk = ~clk;

    odd_ticket_arbiter #(.N_REQ(4), .GAP_CYCLES(0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_clr(clr),
        .o_gnt(gnt_a), .o_gnt_valid(gv_a), .o_ticket(tkt_a),
        .o_wrap(wrap_a), .o_busy(busy_a)
`ifdef ODD_TICKET_ARBITER_STATS_EN
        , .o_grant_total(tot_a)
`endif
    );

    odd_ticket_arbiter #(.N_REQ(4), .GAP_CYCLES(3)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_clr(clr),
        .o_gnt(gnt_b), .o_gnt_valid(gv_b), .o_ticket(tkt_b),
        .o_wrap(wrap_b), .o_busy(busy_b)
`ifdef ODD_TICKET_ARBITER_STATS_EN
        , .o_grant_total(tot_b)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance: next ticket, last winner, edges left before
    // requests are looked at again, grant total.
    int m_ticket [2];
    int m_last   [2];
    int m_cool   [2];
    int m_total  [2];
    int e_gnt    [2];
    int e_tkt    [2];
    int e_wrap   [2];
    int e_busy   [2];

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int d);
        int w;
        e_gnt[d] = 0; e_tkt[d] = 0; e_wrap[d] = 0; e_busy[d] = 0;
        if (!rst_n) begin
            m_ticket[d] = 1; m_last[d] = 3; m_cool[d] = 0; m_total[d] = 0;
            return;
        end
        if (m_cool[d] > 0) begin
            m_cool[d]--;
            e_busy[d] = 1;
        end else if (req != 4'b0000) begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && req[(m_last[d] + k) % 4]) w = (m_last[d] + k) % 4;
            end
            e_gnt[d]    = 1 << w;
            e_tkt[d]    = m_ticket[d];
            e_wrap[d]   = (m_ticket[d] == 255) ? 1 : 0;
            e_busy[d]   = 1;
            m_last[d]   = w;
            m_ticket[d] = (m_ticket[d] + 2) % 256;
            m_cool[d]   = gap_of(d);
            if (m_total[d] < 65535) m_total[d]++;
        end
        if (clr) m_ticket[d] = 1;
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge.
    task automatic step(input logic [3:0] r, input logic c, input logic rn);
        req = r; clr = c; rst_n = rn;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        chk("A.gnt",    32'(gnt_a),  32'(e_gnt[0]));
        chk("A.valid",  32'(gv_a),   32'(e_gnt[0] != 0));
        chk("A.ticket", 32'(tkt_a),  32'(e_tkt[0]));
        chk("A.wrap",   32'(wrap_a), 32'(e_wrap[0]));
        chk("A.busy",   32'(busy_a), 32'(e_busy[0]));
        chk("B.gnt",    32'(gnt_b),  32'(e_gnt[1]));
        chk("B.valid",  32'(gv_b),   32'(e_gnt[1] != 0));
        chk("B.ticket", 32'(tkt_b),  32'(e_tkt[1]));
        chk("B.wrap",   32'(wrap_b), 32'(e_wrap[1]));
        chk("B.busy",   32'(busy_b), 32'(e_busy[1]));
`ifdef ODD_TICKET_ARBITER_STATS_EN
        chk("A.total",  32'(tot_a),  32'(m_total[0]));
        chk("B.total",  32'(tot_b),  32'(m_total[1]));
`endif
    endtask

    initial begin
        logic [3:0] seq_gnt [6];
        rst_n = 1'b0; req = 4'b0000; clr = 1'b0;
        seq_gnt[0] = 4'b0001; seq_gnt[1] = 4'b0010; seq_gnt[2] = 4'b0100;
        seq_gnt[3] = 4'b1000; seq_gnt[4] = 4'b0001; seq_gnt[5] = 4'b0010;

        // Reset dominates requests and clear.
        step(4'b1111, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        chk("rst_gnt",    32'(gnt_a), 32'h0);
        chk("rst_ticket", 32'(tkt_a), 32'h0);
        chk("rst_busy",   32'(busy_a), 32'h0);

        // Single request held one cycle.
        step(4'b0010, 1'b0, 1'b1);
        chk("single_gnt",    32'(gnt_a), 32'h2);
        chk("single_ticket", 32'(tkt_a), 32'd1);
        chk("single_busy",   32'(busy_a), 32'h1);
        step(4'b0000, 1'b0, 1'b1);
        chk("single_idle", 32'(busy_a), 32'h0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b1);

        // Full rotation with tickets 1,3,5,...
        step(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(4'b1111, 1'b0, 1'b1);
            chk("rot_gnt",    32'(gnt_a), 32'(seq_gnt[i]));
            chk("rot_ticket", 32'(tkt_a), 32'(1 + 2 * i));
        end

        // 129 back-to-back grants: wrap at 255, then back to 1.
        step(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 129; i++) begin
            step(4'($urandom_range(1, 15)), 1'b0, 1'b1);
            if (i == 127) begin
                chk("wrap_ticket", 32'(tkt_a), 32'd255);
                chk("wrap_flag",   32'(wrap_a), 32'h1);
            end
            if (i == 128) begin
                chk("after_wrap_ticket", 32'(tkt_a), 32'd1);
                chk("after_wrap_flag",   32'(wrap_a), 32'h0);
            end
        end

        // Clear coincident with the grant carrying 7.
        step(4'b0000, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b1, 1'b1);
        chk("clr_ticket", 32'(tkt_a), 32'd7);
        chk("clr_gnt",    32'(gnt_a), 32'h8);
        step(4'b1111, 1'b0, 1'b1);
        chk("post_clr_ticket", 32'(tkt_a), 32'd1);
        chk("post_clr_gnt",    32'(gnt_a), 32'h1);

        // Gap of 3: a grant every 4th cycle, busy throughout.
        step(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(4'b1111, 1'b0, 1'b1);
            chk("gap_busy", 32'(busy_b), 32'h1);
            chk("gap_valid", 32'(gv_b), 32'((i % 4) == 0));
        end
        chk("gap_third_ticket", 32'(tkt_b), 32'd5);
        // Request raised then dropped during the gap gets nothing.
        step(4'b0100, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b1);
        chk("gap_drop_gnt", 32'(gnt_b), 32'h8);

        // Reset in the middle of granting.
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        chk("midrst_gnt",  32'(gnt_a), 32'h0);
        chk("midrst_busy", 32'(busy_a), 32'h0);
`ifdef ODD_TICKET_ARBITER_STATS_EN
        chk("midrst_total", 32'(tot_a), 32'h0);
`endif
        step(4'b1111, 1'b0, 1'b1);
        chk("midrst_next_gnt",    32'(gnt_a), 32'h1);
        chk("midrst_next_ticket", 32'(tkt_a), 32'd1);

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), ($urandom_range(0, 15) == 0), !($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/odd_ticket_arbiter.md
ODD_TICKET_ARBITER -- requirements
Module: odd_ticket_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (legal 2..8).
REQ-002 Parameter GAP_CYCLES, default 0, idle cycles inserted after each grant (legal 0..15).
REQ-003 Port i_clk input 1 -- single clock, all logic on rising edge.
REQ-004 Port i_rst_n input 1 -- reset, synchronous, active-low.
REQ-005 Port i_req input N_REQ -- level request per requester.
REQ-006 Port i_clr input 1 -- synchronous clear of ticket counter to 1.
REQ-007 Port o_gnt output N_REQ -- one-hot grant, one-cycle pulse, registered.
REQ-008 Port o_gnt_valid output 1 -- high exactly when o_gnt is nonzero.
REQ-009 Port o_ticket output 8 -- odd ticket value handed out, valid only while o_gnt_valid high.
REQ-010 Port o_wrap output 1 -- pulses with the grant whose o_ticket is 255.
REQ-011 Port o_busy output 1 -- high in GRANT and GAP states.

Function
REQ-012 Internal 8-bit ticket counter shall hold only odd values; it starts at 1 and advances by 2 after each grant, modulo 256 (255 -> 1).
REQ-013 FSM states IDLE, GRANT, GAP; IDLE -> GRANT when any i_req bit high; GRANT -> GAP when GAP_CYCLES > 0; GRANT -> GRANT when GAP_CYCLES = 0 and any i_req high; GRANT -> IDLE otherwise; GAP -> IDLE after exactly GAP_CYCLES cycles in GAP.
REQ-014 Arbitration shall be round-robin: search starts at index (last granted + 1) mod N_REQ; winner is first set i_req bit in that order.
REQ-015 Requests are sampled on the edge that enters GRANT; grant appears the cycle after sampling (latency 1 from request to o_gnt).
REQ-016 A requester receives at most one grant per arbitration; with GAP_CYCLES = 0 and all requests held high, grants rotate 0,1,2,...,N_REQ-1,0 on consecutive cycles.
REQ-017 o_ticket shall equal the counter value before the post-grant increment; consecutive grants carry consecutive odd values.
REQ-018 Requests arriving or dropping while in GAP are ignored until GAP exits; a request dropped before sampling gets no grant.
REQ-019 i_clr asserted with no grant in flight: counter = 1 next cycle. i_clr coincident with a grant: grant carries current value, counter = 1 next cycle (clear wins over increment).
REQ-020 i_clr shall not affect FSM state, round-robin pointer or o_gnt.
REQ-021 o_wrap high only in the cycle o_gnt_valid high and o_ticket = 255.

Reset
REQ-022 When i_rst_n low at a rising edge: FSM -> IDLE, counter -> 1, pointer -> so requester 0 has highest priority, GAP timer -> 0.
REQ-023 Reset values: o_gnt = 0, o_gnt_valid = 0, o_ticket = 0, o_wrap = 0, o_busy = 0.
REQ-024 Reset mid-GRANT or mid-GAP shall abort immediately; no grant pulse is produced in the cycle after reset is sampled.
REQ-025 Reset shall dominate i_clr and i_req.

Configuration
REQ-026 Macro ODD_TICKET_ARBITER_STATS_EN: when defined, adds output o_grant_total (16 bits), reset 0, +1 per grant, saturating at 65535, unaffected by i_clr.
REQ-027 Without ODD_TICKET_ARBITER_STATS_EN the port and counter shall not exist; all other behaviour identical.

Verification
REQ-028 Reset, then i_req=4'b0010 held one cycle -> next cycle o_gnt=4'b0010, o_ticket=1, o_busy=1; then IDLE.
REQ-029 GAP_CYCLES=0, i_req=4'b1111 held 6 cycles -> o_gnt 0001,0010,0100,1000,0001,0010 with tickets 1,3,5,7,9,11.
REQ-030 Drive 128 grants -> 128th grant o_ticket=255 with o_wrap=1; 129th grant o_ticket=1, o_wrap=0.
REQ-031 i_clr coincident with grant carrying 7 -> o_ticket=7 that cycle; next grant o_ticket=1; pointer rotation unchanged.
REQ-032 GAP_CYCLES=3, i_req=4'b1111 held -> grants every 4th cycle, o_busy high throughout, requests dropped during GAP not granted.
REQ-033 i_rst_n low during GRANT with STATS_EN defined -> next cycle o_gnt=0, o_grant_total=0, next grant o_ticket=1 to requester 0.
